scoreboard_regfile: RTL
=======================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2).
REQ-003 The block SHALL use derived localparam AW = $clog2(NREGS) for all address widths.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 i_rd_addr_1  in  AW  read port 1 address.
REQ-007 o_rd_data_1  out  XLEN  read port 1 data, combinational.
REQ-008 o_rd_busy_1  out  1  read port 1 register has pending write, combinational.
REQ-009 i_rd_addr_2 / o_rd_data_2 / o_rd_busy_2  in AW / out XLEN / out 1  read port 2, identical to port 1.
REQ-010 i_alloc_valid  in  1  request to mark destination register busy.
REQ-011 i_alloc_addr  in  AW  destination register to allocate.
REQ-012 o_alloc_ready  out  1  allocation accepted this cycle, combinational.
REQ-013 i_wb0_valid, i_wb0_addr, i_wb0_data  in  1, AW, XLEN  writeback port 0.
REQ-014 i_wb1_valid, i_wb1_addr, i_wb1_data  in  1, AW, XLEN  writeback port 1.
REQ-015 i_flush  in  1  clear all busy bits; register data retained.
REQ-016 o_busy_vec  out  NREGS  registered busy bit per register.

Function
REQ-017 Register 0 SHALL read 0, SHALL never be busy, and writes/allocations to it SHALL have no state effect.
REQ-018 o_alloc_ready SHALL be 1 when i_alloc_addr==0 or busy[i_alloc_addr]==0, else 0 (WAW stall), regardless of same-cycle writeback.
REQ-019 Allocation fires when i_alloc_valid && o_alloc_ready; busy[i_alloc_addr] SHALL be 1 the next cycle.
REQ-020 A valid writeback SHALL update register data and clear its busy bit at the next edge; writes to non-busy registers are legal.
REQ-021 wb0 and wb1 to the same nonzero address in one cycle: wb1 data SHALL win; busy cleared.
REQ-022 Allocation and writeback to the same address in one cycle: data written, busy SHALL be set (set beats clear).
REQ-023 i_flush SHALL clear every busy bit at the next edge, overriding same-cycle allocation; same-cycle writeback data SHALL still be written.
REQ-024 o_rd_busy_n SHALL equal busy[i_rd_addr_n] except as modified by REQ-029.
REQ-025 Without bypass, write-to-read latency SHALL be 1 cycle; reads return the stored value.

Reset
REQ-026 reset SHALL clear all registers to 0 and all busy bits to 0 at the next edge, overriding all other inputs.
REQ-027 After reset: o_busy_vec=0, o_rd_data_n=0, o_rd_busy_n=0, o_alloc_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard pending busy state; no writeback in that cycle takes effect.

Configuration
REQ-029 With macro SCOREBOARD_REGFILE_BYPASS_EN defined, a read whose nonzero address matches a same-cycle valid writeback SHALL return that writeback data (wb1 priority) and report busy 0; a same-cycle allocation to that address does not affect the read.
REQ-030 Without SCOREBOARD_REGFILE_BYPASS_EN, no forwarding logic SHALL exist and REQ-025 applies.

Verification
REQ-031 Reset, then read x5 on both ports -> data 0, busy 0, o_busy_vec 0.
REQ-032 Alloc x7; next cycle read x7 -> busy 1, o_alloc_ready 0 for x7; wb0 x7=0xDEADBEEF -> next cycle busy 0, data 0xDEADBEEF.
REQ-033 wb0 x3=0x11 and wb1 x3=0x22 same cycle -> x3 reads 0x22 next cycle.
REQ-034 Alloc x9 and wb1 x9=0x55 same cycle -> next cycle x9=0x55, busy[9]=1.
REQ-035 Alloc x1,x2,x4; flush with alloc x6 same cycle -> next cycle o_busy_vec=0; wb0 x0=0xFF -> x0 reads 0.
REQ-036 Bypass build: wb0 x10=0xCAFE with read port 1 at x10 same cycle -> o_rd_data_1=0xCAFE, o_rd_busy_1=0; non-bypass build -> old value, 0xCAFE next cycle.

Source files
------------

// File: rtl/scoreboard_regfile.sv
// Register file with a per-register busy scoreboard, two read ports, one allocation port and two writeback ports.
// Define SCOREBOARD_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module scoreboard_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    i_rd_addr_1,
   output logic [XLEN-1:0]  o_rd_data_1,
   output logic             o_rd_busy_1,
   input  logic [AW-1:0]    i_rd_addr_2,
   output logic [XLEN-1:0]  o_rd_data_2,
   output logic             o_rd_busy_2,
   input  logic             i_alloc_valid,
   input  logic [AW-1:0]    i_alloc_addr,
   output logic             o_alloc_ready,
   input  logic             i_wb0_valid,
   input  logic [AW-1:0]    i_wb0_addr,
   input  logic [XLEN-1:0]  i_wb0_data,
   input  logic             i_wb1_valid,
   input  logic [AW-1:0]    i_wb1_addr,
   input  logic [XLEN-1:0]  i_wb1_data,
   input  logic             i_flush,
   output logic [NREGS-1:0] o_busy_vec
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic             alloc_fire;

   // A WAW stall depends only on the registered busy bit, never on a same-cycle writeback.
   assign o_alloc_ready = (i_alloc_addr == '0) || !busy_q[i_alloc_addr];
   assign alloc_fire    = i_alloc_valid && o_alloc_ready;
   assign o_busy_vec    = busy_q;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (i_wb0_valid && i_wb0_addr != '0) begin
         regs_d[i_wb0_addr] = i_wb0_data;
         busy_d[i_wb0_addr] = 1'b0;
      end
      // wb1 is applied second so it wins on an address collision.
      if (i_wb1_valid && i_wb1_addr != '0) begin
         regs_d[i_wb1_addr] = i_wb1_data;
         busy_d[i_wb1_addr] = 1'b0;
      end
      if (alloc_fire)
         busy_d[i_alloc_addr] = 1'b1;
      if (i_flush)
         busy_d = '0;
      busy_d[0] = 1'b0;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      o_rd_data_1 = regs_q[i_rd_addr_1];
      o_rd_busy_1 = busy_q[i_rd_addr_1];
      o_rd_data_2 = regs_q[i_rd_addr_2];
      o_rd_busy_2 = busy_q[i_rd_addr_2];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
      if (i_rd_addr_1 != '0) begin
         if (i_wb1_valid && i_wb1_addr == i_rd_addr_1) begin
            o_rd_data_1 = i_wb1_data;
            o_rd_busy_1 = 1'b0;
         end else if (i_wb0_valid && i_wb0_addr == i_rd_addr_1) begin
            o_rd_data_1 = i_wb0_data;
            o_rd_busy_1 = 1'b0;
         end
      end
      if (i_rd_addr_2 != '0) begin
         if (i_wb1_valid && i_wb1_addr == i_rd_addr_2) begin
            o_rd_data_2 = i_wb1_data;
            o_rd_busy_2 = 1'b0;
         end else if (i_wb0_valid && i_wb0_addr == i_rd_addr_2) begin
            o_rd_data_2 = i_wb0_data;
            o_rd_busy_2 = 1'b0;
         end
      end
`endif
   end

endmodule
